aes256_round_ctrl: RTL and testbench
====================================

// Module: aes256_round_ctrl
// PURPOSE
//   Iterative AES-256 encryption sequencer. Owns the 128-bit state register and
//   drives one one_round instance and one final_round instance. Both have
//   2-cycle rounds because their table lookups are registered.
//   Accepts one block per valid/ready handshake, runs the initial AddRoundKey,
//   then NR-1 full rounds and one final round. Returns the ciphertext on an
//   output handshake. Round keys come from an external key-schedule store,
//   indexed by rk_idx.
// PARAMETERS
//   NR      14  total rounds (14 = AES-256); round-key indices 0..NR
//   PHASES  2   cycles per round (datapath latency + 1); must be >= 2
// PORTS
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous assert, active-low reset
//   in_valid   in   1    plaintext block offered
//   in_ready   out  1    controller can accept a block
//   in_data    in   128  plaintext, {s0,s1,s2,s3}, s0 is MS word
//   out_valid  out  1    ciphertext available
//   out_ready  in   1    sink accepts ciphertext
//   out_data   out  128  ciphertext, held stable while out_valid && !out_ready
//   rk_idx     out  4    round-key index requested (0..NR); combinational key return
//   rk_data    in   128  round key for rk_idx, valid in the same cycle
//   rnd_state  out  128  state_in to one_round and final_round (= state_reg)
//   rnd_key    out  128  key to both round instances (= rk_data)
//   rnd_out    in   128  one_round state_out, valid PHASES-1 cycles after rnd_state is set up
//   fin_out    in   128  final_round state_out, same timing as rnd_out
//   abort      in   1    only when AES_ROUND_CTRL_ABORT_EN is defined
// BEHAVIOUR
//   Reset values:
//     FSM=IDLE, in_ready=1, out_valid=0, out_data=0, state_reg=0, rnd=0,
//     phase=0, rk_idx=0.
//   FSM states: IDLE, ROUND, FINAL, DONE.
//   IDLE:
//     - in_ready=1, rk_idx=0.
//     - On in_valid: state_reg<=in_data^rk_data; rnd<=1; phase<=0; go to ROUND.
//   ROUND:
//     - rk_idx=rnd. phase counts 0..PHASES-1.
//     - At phase=PHASES-1: state_reg<=rnd_out; rnd<=rnd+1; phase<=0.
//     - If rnd==NR-1 at that edge, go to FINAL.
//   FINAL:
//     - rk_idx=NR. At phase=PHASES-1: out_data<=fin_out; out_valid<=1; go to DONE.
//   DONE:
//     - out_valid=1 and in_ready=0; out_data is held.
//     - On out_ready: out_valid<=0; go to IDLE.
//     - No same-cycle accept: a new block is accepted in the following IDLE cycle.
//   Latency:
//     - Accept edge to out_valid rising = NR*PHASES cycles (28 at defaults).
//     - Issue interval = NR*PHASES+2 cycles with out_ready held high.
//   rnd is 4 bits and never exceeds NR; NR must be <= 15.
//   rk_idx must equal rnd through the whole round, because the key is XORed
//   combinationally at capture.
//   in_valid outside IDLE is ignored; in_data need not be held after accept.
//   out_ready in IDLE, ROUND or FINAL has no effect.
//   Reset asserted mid-operation: immediately returns to reset values; the
//   in-flight block is discarded with no output.
// CONFIGURATION
//   AES_ROUND_CTRL_ABORT_EN defined:
//     - Adds the abort input. abort=1 in ROUND or FINAL forces IDLE at the next
//       edge; rnd, phase and state_reg are cleared; out_valid stays 0.
//     - abort in DONE is ignored; the result must still be handshaken.
//     - abort in IDLE blocks acceptance in that cycle.
//   AES_ROUND_CTRL_ABORT_EN undefined:
//     - No abort port; the block always completes.
// STRUCTURE
//   Package aes256_pkg:
//     - AES_NR=14, AES_BLK_W=128, AES_WORD_W=32, RK_IDX_W=4.
//     - typedef enum {IDLE,ROUND,FINAL,DONE} aes_ctrl_st_t.
//   Sub-module aes256_round_timer holds the phase and rnd counters.
//     - Outputs: round_tick (phase==PHASES-1), last_full (rnd==NR-1).
//     - Inputs: start, clear.
//   The FSM, state_reg and output register stay in aes256_round_ctrl.
// TESTING (bench instantiates real one_round/final_round and a FIPS-197 key store)
//   1. Key 000102..1f, PT 00112233445566778899aabbccddeeff
//      -> out_data=8ea2b7ca516745bfeafc49904b496089, out_valid 28 cycles after accept.
//   2. Two blocks back-to-back, out_ready=1 -> second accepted exactly 30 cycles
//      after the first; both ciphertexts correct.
//   3. out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0,
//      in_valid pulses ignored; release -> IDLE next cycle.
//   4. in_valid toggled during ROUND with random in_data -> no effect on result;
//      rk_idx sequence 0,1,1,2,2,..,13,13,14,14.
//   5. rst_n low at round 7 -> outputs at reset values asynchronously; the next
//      block after reset gives correct output.
//   6. (ABORT_EN) abort at round 5 -> IDLE next edge, no out_valid; next block
//      gives the vector-1 result.

Source files
------------

// File: rtl/aes256_pkg.sv
// Shared types and constants for the iterative AES-256 encryption controller.
package aes256_pkg;

    localparam int unsigned AES_NR     = 14;
    localparam int unsigned AES_BLK_W  = 128;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned RK_IDX_W   = 4;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } aes_ctrl_st_t;

    // Round-key index to present for a given controller state. The key store
    // returns combinationally and the key is XORed at capture, so the index
    // must be stable for the whole round.
    function automatic logic [RK_IDX_W-1:0] rk_select(
        input aes_ctrl_st_t          st,
        input logic [RK_IDX_W-1:0]   rnd,
        input int unsigned           nr
    );
        case (st)
            ROUND:   return rnd;
            FINAL:   return RK_IDX_W'(nr);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/aes256_round_ctrl_if.sv
// Block-in / block-out handshake bundle for aes256_round_ctrl.
// master = block source and ciphertext sink, slave = the controller.
interface aes256_round_ctrl_if;
    import aes256_pkg::*;

    logic     in_valid;
    logic     in_ready;
    aes_blk_t in_data;
    logic     out_valid;
    logic     out_ready;
    aes_blk_t out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/aes256_round_timer.sv
// Phase and round counters for the AES-256 round sequencer.
// phase counts 0..PHASES-1 while running; rnd advances at the last phase and
// saturates at NR. clear has priority over start, start over run.
module aes256_round_timer
    import aes256_pkg::*;
#(
    parameter int unsigned NR     = AES_NR,
    parameter int unsigned PHASES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clear,
    input  logic                run,
    output logic [RK_IDX_W-1:0] rnd,
    output logic                round_tick,
    output logic                last_full
);

    localparam int unsigned         PH_W      = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0]     PH_LAST   = PH_W'(PHASES - 1);
    localparam logic [RK_IDX_W-1:0] RND_MAX   = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] RND_LASTF = RK_IDX_W'(NR - 1);
    localparam logic [RK_IDX_W-1:0] RND_ONE   = RK_IDX_W'(1);

    logic [PH_W-1:0]     phase_d, phase_q;
    logic [RK_IDX_W-1:0] rnd_d, rnd_q;

    // Next-count logic: clear, then start, then normal phase/round stepping.
    always_comb begin
        phase_d = phase_q;
        rnd_d   = rnd_q;
        if (clear) begin
            phase_d = '0;
            rnd_d   = '0;
        end else if (start) begin
            phase_d = '0;
            rnd_d   = RND_ONE;
        end else if (run) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                if (rnd_q != RND_MAX) begin
                    rnd_d = rnd_q + RND_ONE;
                end
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            rnd_q   <= '0;
        end else begin
            phase_q <= phase_d;
            rnd_q   <= rnd_d;
        end
    end

    assign rnd        = rnd_q;
    assign round_tick = (phase_q == PH_LAST);
    assign last_full  = (rnd_q == RND_LASTF);

endmodule

// File: rtl/aes256_round_ctrl.sv
// Iterative AES-256 encryption sequencer.
// Owns the 128-bit state register, drives external one_round/final_round
// instances (registered lookups, PHASES cycles per round) and requests round
// keys from an external key store by index.
// Optional feature: define AES_ROUND_CTRL_ABORT_EN to add the abort input,
// which cancels an in-flight block from ROUND or FINAL.
module aes256_round_ctrl
    import aes256_pkg::*;
#(
    parameter int unsigned NR     = AES_NR,
    parameter int unsigned PHASES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes256_round_ctrl_if.slave   bus,
    output logic [RK_IDX_W-1:0]  rk_idx,
    input  aes_blk_t             rk_data,
    output aes_blk_t             rnd_state,
    output aes_blk_t             rnd_key,
    input  aes_blk_t             rnd_out,
    input  aes_blk_t             fin_out
`ifdef AES_ROUND_CTRL_ABORT_EN
    ,
    input  logic                 abort
`endif
);

    aes_ctrl_st_t        st_d, st_q;
    aes_blk_t            state_d, state_q;
    aes_blk_t            out_data_d, out_data_q;
    logic                out_valid_d, out_valid_q;
    logic                tmr_start, tmr_clear, tmr_run;
    logic                round_tick, last_full;
    logic                abort_req;
    logic [RK_IDX_W-1:0] rnd;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign tmr_run = (st_q == ROUND) || (st_q == FINAL);

    aes256_round_timer #(
        .NR     (NR),
        .PHASES (PHASES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (tmr_start),
        .clear      (tmr_clear),
        .run        (tmr_run),
        .rnd        (rnd),
        .round_tick (round_tick),
        .last_full  (last_full)
    );

    // Sequencer: accept, full rounds, final round, hold result until taken.
    // The timer is cleared on entry to DONE so rnd reads 0 outside a block.
    always_comb begin
        st_d        = st_q;
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        tmr_start   = 1'b0;
        tmr_clear   = 1'b0;
        case (st_q)
            IDLE: begin
                if (bus.in_valid && !abort_req) begin
                    state_d   = bus.in_data ^ rk_data;
                    tmr_start = 1'b1;
                    st_d      = ROUND;
                end
            end
            ROUND: begin
                if (abort_req) begin
                    state_d   = '0;
                    tmr_clear = 1'b1;
                    st_d      = IDLE;
                end else if (round_tick) begin
                    state_d = rnd_out;
                    if (last_full) begin
                        st_d = FINAL;
                    end
                end
            end
            FINAL: begin
                if (abort_req) begin
                    state_d   = '0;
                    tmr_clear = 1'b1;
                    st_d      = IDLE;
                end else if (round_tick) begin
                    out_data_d  = fin_out;
                    out_valid_d = 1'b1;
                    tmr_clear   = 1'b1;
                    st_d        = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    st_d        = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    // Controller, state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            state_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (st_q == IDLE) && !abort_req;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign rk_idx    = rk_select(st_q, rnd, NR);
    assign rnd_state = state_q;
    assign rnd_key   = rk_data;

endmodule

// File: tb/tb_aes256_round_ctrl.sv
// Self-checking bench for aes256_round_ctrl with behavioural one_round /
// final_round instances (one registered stage each) and an AES-256 key store.
module tb_aes256_round_ctrl;
    import aes256_pkg::*;

    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT2 = 128'hffeeddccbbaa99887766554433221100;
    localparam int unsigned  LAT = 28;

    typedef struct {
        logic [127:0] exp;
        int unsigned  acc;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                abort;
    logic [RK_IDX_W-1:0] rk_idx;
    logic [127:0]        rk_data, rnd_state, rnd_key;
    logic [127:0]        rnd_out_q, fin_out_q;
    logic [127:0]        rk_mem [16];
    logic [7:0]          sbox [256];
    logic [127:0]        ct2;
    int unsigned         cyc = 0;
    int unsigned         total = 0;
    int unsigned         passed = 0;
    exp_t                sb [$];
    logic                ov_prev = 1'b0;

    aes256_round_ctrl_if ifc ();

    aes256_round_ctrl #(
        .NR     (14),
        .PHASES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .rnd_state (rnd_state),
        .rnd_key   (rnd_key),
        .rnd_out   (rnd_out_q),
        .fin_out   (fin_out_q)
`ifdef AES_ROUND_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                t[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_mem[0];
        for (int r = 1; r < 14; r++) s = aes_round(s, rk_mem[r], 1'b0);
        return aes_round(s, rk_mem[14], 1'b1);
    endfunction

    // Round instances: one registered stage each, so output is valid
    // PHASES-1 = 1 cycle after state/key are presented.
    always @(posedge clk) begin
        rnd_out_q <= aes_round(rnd_state, rnd_key, 1'b0);
        fin_out_q <= aes_round(rnd_state, rnd_key, 1'b1);
    end

    assign rk_data = rk_mem[rk_idx];

    // ---------------- checking helpers ----------------
    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        else passed++;
    endfunction

    function automatic void flag_fail(input string nm);
        total++;
        $display("FAIL %s: got event expected none/bounded (cycle %0d)", nm, cyc);
    endfunction

    // Monitor: on each rising out_valid compare data and latency against the
    // scoreboard head; pop on the output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ov_prev = 1'b0;
                continue;
            end
            if (ifc.out_valid && !ov_prev) begin
                if (sb.size() == 0) begin
                    flag_fail("unexpected_out");
                end else begin
                    chk("ciphertext", ifc.out_data, sb[0].exp);
                    chk("latency", 128'(cyc - sb[0].acc), 128'(LAT));
                end
            end
            if (ifc.out_valid && ifc.out_ready && sb.size() > 0) void'(sb.pop_front());
            ov_prev = ifc.out_valid;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] exp, output int unsigned acc);
        int unsigned n;
        n = 0;
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = pt;
        forever begin
            @(negedge clk);
            if (ifc.in_ready) break;
            n++;
            if (n > 200) begin
                flag_fail("accept_timeout");
                break;
            end
        end
        acc = cyc + 1;
        sb.push_back('{exp: exp, acc: acc});
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (sb.size() == 0 && !ifc.out_valid) break;
            n++;
            if (n > 200) begin
                flag_fail("drain_timeout");
                sb.delete();
                break;
            end
        end
    endtask

    task automatic wait_rk(input logic [RK_IDX_W-1:0] v);
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rk_idx == v) break;
            n++;
            if (n > 100) begin
                flag_fail("wait_rk_timeout");
                break;
            end
        end
    endtask

    task automatic wait_ov();
        int unsigned n;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifc.out_valid) break;
            n++;
            if (n > 100) begin
                flag_fail("wait_ov_timeout");
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int unsigned  a1, a2;
        logic [31:0]  w [60];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   inv;

        rst_n         = 1'b0;
        abort         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_data   = '0;
        ifc.out_ready = 1'b1;

        // S-box from GF(2^8) inverse plus affine map
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        // AES-256 key expansion into the key store
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = KEY[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk_mem[15] = '0;
        ct2 = aes_enc(PT2);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(ifc.in_ready), 128'(1));
        chk("rst_out_valid", 128'(ifc.out_valid), 128'(0));
        chk("rst_out_data", ifc.out_data, 128'(0));
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk("rst_state", rnd_state, 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: FIPS-197 vector
        send(PT1, CT1, a1);
        drain();

        // 2: back-to-back with out_ready held high
        send(PT1, CT1, a1);
        send(PT2, ct2, a2);
        chk("issue_gap", 128'(a2 - a1), 128'(LAT + 2));
        drain();

        // 3: result held while sink stalls; input ignored in DONE
        ifc.out_ready = 1'b0;
        send(PT2, ct2, a1);
        wait_ov();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            ifc.in_valid = 1'($urandom_range(0, 1));
            ifc.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("hold_data", ifc.out_data, ct2);
            chk("hold_in_ready", 128'(ifc.in_ready), 128'(0));
            chk("hold_out_valid", 128'(ifc.out_valid), 128'(1));
        end
        @(posedge clk); #1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 128'(ifc.in_ready), 128'(1));
        chk("release_out_valid", 128'(ifc.out_valid), 128'(0));
        chk("release_sb_empty", 128'(sb.size()), 128'(0));

        // 4: round-key index sequence, in_valid noise during rounds
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.in_data  = PT1;
        @(negedge clk);
        chk("accept_ready", 128'(ifc.in_ready), 128'(1));
        chk("rk_seq_0", 128'(rk_idx), 128'(0));
        sb.push_back('{exp: CT1, acc: cyc + 1});
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk); #1;
            ifc.in_valid = 1'($urandom_range(0, 1));
            ifc.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk($sformatf("rk_seq_%0d", k), 128'(rk_idx), 128'((k + 1) / 2));
        end
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        drain();

        // 5: asynchronous reset mid-block, then a clean block
        send(PT1, CT1, a1);
        wait_rk(4'd7);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_in_ready", 128'(ifc.in_ready), 128'(1));
        chk("arst_out_valid", 128'(ifc.out_valid), 128'(0));
        chk("arst_out_data", ifc.out_data, 128'(0));
        chk("arst_rk_idx", 128'(rk_idx), 128'(0));
        chk("arst_state", rnd_state, 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(PT2, ct2, a1);
        drain();

`ifdef AES_ROUND_CTRL_ABORT_EN
        // 6: abort mid-block, no output, then a clean block
        send(PT1, CT1, a1);
        wait_rk(4'd5);
        @(posedge clk); #1;
        abort = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 128'(ifc.in_ready), 128'(1));
        chk("abort_out_valid", 128'(ifc.out_valid), 128'(0));
        chk("abort_state", rnd_state, 128'(0));
        chk("abort_rk_idx", 128'(rk_idx), 128'(0));
        repeat (40) @(negedge clk);
        send(PT1, CT1, a1);
        drain();
`endif

        chk("final_sb_empty", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
